// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Request/response front end for an APB completer such as the GPIO block.
// Accepts one transfer at a time on a valid/ready request channel. It runs
// the APB SETUP and ACCESS phases and waits on PREADY. Read data and error
// status are returned on a valid/ready response channel.
//
// Optional feature macro: APB_TIMEOUT_EN
//   Defined   - ACCESS is aborted after TIMEOUT_CYCLES cycles with PREADY
//               low. The response then reports rsp_err=1 and rsp_timeout=1.
//   Undefined - ACCESS waits on PREADY indefinitely and rsp_timeout is 0.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  // request channel
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  // response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  // APB requester port
  output logic                    PSELx,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;

  // Reject configurations that cannot work: the strobe needs whole bytes,
  // and a zero-cycle timeout would abort before the completer is sampled.
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("apb_master_bridge: DATA_WIDTH must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // The bridge is ready only in IDLE. This output is combinational, so it
  // is forced low while reset is asserted and never advertises acceptance
  // during reset.
  assign req_ready = (state == IDLE) && PRESETn;

  // Transfer sequencer. It registers every APB and response output.
  // Request fields are sampled only when a request is accepted in IDLE.
  // The APB address/data/strobe registers keep their values after the
  // transfer completes.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            PWRITE  <= req_write;
            PADDR   <= req_addr;
            PWDATA  <= req_wdata;
            PSTRB   <= req_write ? req_strb : {STRB_W{1'b0}};
            PSELx   <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          PENABLE  <= 1'b1;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state    <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            rsp_rdata <= PWRITE ? {DATA_WIDTH{1'b0}} : PRDATA;
            rsp_err   <= PSLVERR;
`ifdef APB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            wait_cnt  <= wait_cnt + 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            timeout_q <= 1'b1;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Bench for apb_master_bridge. A small APB completer model with
// programmable wait states, error and read data sits behind the bridge.
// Expected responses are queued when requests are issued and popped when
// the bridge presents a response.
// The timeout scenario follows APB_TIMEOUT_EN in the same way as the design.
module tb_apb_master_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } exp_t;

  logic          PCLK;
  logic          PRESETn;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  // completer model controls
  int            slave_wait;
  bit            slave_stuck;
  bit            slave_err;
  bit            use_addr_data;
  logic [DW-1:0] slave_rdata;
  int            acc_cnt = 0;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  apb_master_bridge #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_strb(req_strb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSELx(PSELx),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PSTRB(PSTRB),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // cycle counter used to measure request spacing
  always @(posedge PCLK) cyc <= cyc + 1;

  // completer wait-state counter, cleared whenever no ACCESS wait is pending
  always @(posedge PCLK) begin
    if (PSELx && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  // completer response: PRDATA/PSLVERR carry junk outside the ready cycle
  always_comb begin
    PREADY  = PSELx && PENABLE && !slave_stuck && (acc_cnt >= slave_wait);
    PRDATA  = 32'hBAD0_BAD0;
    PSLVERR = PSELx && PENABLE;
    if (PREADY) begin
      PRDATA  = use_addr_data ? {~PADDR[15:0], PADDR[15:0]} : slave_rdata;
      PSLVERR = slave_err;
    end
  end

  // Drive a request from a negedge and hold it until accepted. On return the
  // bench is at the negedge of the cycle after acceptance (SETUP), and the
  // request fields have been scrambled.
  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, output bit ok);
    req_write = w; req_addr = a; req_wdata = d; req_strb = s; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge PCLK);
    end
    if (ok) @(negedge PCLK);
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_strb  = SW'($urandom);
  endtask

  // Wait on negedges until rsp_valid is high, or until the bound expires.
  task automatic wait_rsp(output exp_t got, output bit ok);
    ok = 1'b0;
    got = '0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        got = '{rdata: rsp_rdata, err: rsp_err, to: rsp_timeout};
        break;
      end
      @(negedge PCLK);
    end
  endtask

  task automatic test_reset;
    PRESETn = 1'b0;
    req_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE, PWRITE} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b want 0000000",
               {req_ready, rsp_valid, rsp_err, rsp_timeout, PSELx, PENABLE, PWRITE});
    end
    n_cmp++;
    if ({rsp_rdata, PADDR, PWDATA, PSTRB} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got rdata=%h addr=%h wdata=%h strb=%h want all 0",
               rsp_rdata, PADDR, PWDATA, PSTRB);
    end
    repeat (3) @(negedge PCLK);
    req_valid = 1'b0;
    PRESETn = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_write_zero_wait;
    bit ok; exp_t got, e;
    @(negedge PCLK);
    slave_wait = 0; slave_err = 0; slave_stuck = 0; use_addr_data = 0; rsp_ready = 1;
    sb_q.push_back('{rdata: '0, err: 1'b0, to: 1'b0});
    issue(1'b1, 32'h04, 32'hA5A5_0F0F, 4'hF, ok);
    n_cmp++;
    if (!ok || PSELx !== 1'b1 || PENABLE !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wr_setup: got ok=%b psel=%b pen=%b rdy=%b want 1 1 0 0",
               ok, PSELx, PENABLE, req_ready);
    end
    @(negedge PCLK);
    n_cmp++;
    if ({PSELx, PENABLE, PWRITE, PSTRB, PADDR, PWDATA} !== {3'b111, 4'hF, 32'h04, 32'hA5A5_0F0F}) begin
      n_fail++;
      $display("[TB] FAIL wr_access: got sel=%b en=%b wr=%b strb=%h addr=%h wdata=%h want 1 1 1 f 4 a5a50f0f",
               PSELx, PENABLE, PWRITE, PSTRB, PADDR, PWDATA);
    end
    @(negedge PCLK);
    n_cmp++;
    if (rsp_valid !== 1'b1 || PSELx !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wr_rsp_cycle3: got valid=%b psel=%b want 1 0", rsp_valid, PSELx);
    end
    wait_rsp(got, ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (!ok || got !== e) begin
      n_fail++;
      $display("[TB] FAIL wr_rsp: got ok=%b %h/%b/%b want %h/%b/%b",
               ok, got.rdata, got.err, got.to, e.rdata, e.err, e.to);
    end
    @(negedge PCLK);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wr_back_idle: got valid=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_read_wait;
    bit ok, stable; int pen; exp_t got, e;
    @(negedge PCLK);
    slave_wait = 3; slave_err = 0; slave_rdata = 32'h1234_5678; use_addr_data = 0;
    sb_q.push_back('{rdata: 32'h1234_5678, err: 1'b0, to: 1'b0});
    issue(1'b0, 32'h08, 32'hDEAD_BEEF, 4'hF, ok);
    @(negedge PCLK);
    pen = 0; stable = 1'b1;
    while (PENABLE === 1'b1 && pen < 50) begin
      pen++;
      if (PADDR !== 32'h08 || PSTRB !== 4'h0 || PWRITE !== 1'b0 || PSELx !== 1'b1) stable = 1'b0;
      @(negedge PCLK);
    end
    n_cmp++;
    if (!ok || pen != 4) begin
      n_fail++;
      $display("[TB] FAIL rd_penable_cycles: got ok=%b cycles=%0d want 1 4", ok, pen);
    end
    n_cmp++;
    if (!stable) begin
      n_fail++;
      $display("[TB] FAIL rd_addr_stable: got unstable PADDR/PSTRB/PWRITE want addr=8 strb=0 wr=0");
    end
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rd_rsp_cycle6: got valid=%b want 1", rsp_valid);
    end
    wait_rsp(got, ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (!ok || got !== e) begin
      n_fail++;
      $display("[TB] FAIL rd_rsp: got ok=%b %h/%b/%b want %h/%b/%b",
               ok, got.rdata, got.err, got.to, e.rdata, e.err, e.to);
    end
  endtask

  task automatic test_slave_error;
    bit ok; exp_t got, e;
    @(negedge PCLK);
    slave_wait = 1; slave_err = 1;
    sb_q.push_back('{rdata: '0, err: 1'b1, to: 1'b0});
    issue(1'b1, 32'h0C, 32'h0000_00FF, 4'h1, ok);
    wait_rsp(got, ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (!ok || got !== e) begin
      n_fail++;
      $display("[TB] FAIL err_rsp: got ok=%b %h/%b/%b want %h/%b/%b",
               ok, got.rdata, got.err, got.to, e.rdata, e.err, e.to);
    end
    @(negedge PCLK);
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL err_back_idle: got rdy=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    slave_err = 0;
  endtask

  task automatic test_backpressure;
    bit ok, hold_ok; exp_t got, e;
    @(negedge PCLK);
    slave_wait = 0; slave_err = 0; slave_rdata = 32'hCAFE_F00D; rsp_ready = 0;
    sb_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0, to: 1'b0});
    issue(1'b0, 32'h20, 32'h0, 4'hF, ok);
    wait_rsp(got, ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (!ok || got !== e) begin
      n_fail++;
      $display("[TB] FAIL bp_first_rsp: got ok=%b %h/%b/%b want %h/%b/%b",
               ok, got.rdata, got.err, got.to, e.rdata, e.err, e.to);
    end
    sb_q.push_back('{rdata: '0, err: 1'b0, to: 1'b0});
    req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0000_0055; req_strb = 4'h3;
    req_valid = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || req_ready !== 1'b0 ||
          PSELx !== 1'b0 || PADDR !== 32'h20) hold_ok = 1'b0;
      @(negedge PCLK);
    end
    n_cmp++;
    if (!hold_ok) begin
      n_fail++;
      $display("[TB] FAIL bp_hold: got valid=%b rdata=%h rdy=%b psel=%b addr=%h want 1 cafef00d 0 0 20",
               rsp_valid, rsp_rdata, req_ready, PSELx, PADDR);
    end
    rsp_ready = 1;
    @(negedge PCLK);
    n_cmp++;
    if (req_ready !== 1'b1 || PSELx !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_release: got rdy=%b psel=%b valid=%b want 1 0 0", req_ready, PSELx, rsp_valid);
    end
    @(negedge PCLK);
    req_valid = 1'b0;
    n_cmp++;
    if ({PSELx, PENABLE, PWRITE, PADDR, PSTRB, PWDATA} !== {3'b101, 32'h10, 4'h3, 32'h55}) begin
      n_fail++;
      $display("[TB] FAIL bp_second_setup: got sel=%b en=%b wr=%b addr=%h strb=%h wdata=%h want 1 0 1 10 3 55",
               PSELx, PENABLE, PWRITE, PADDR, PSTRB, PWDATA);
    end
    wait_rsp(got, ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (!ok || got !== e) begin
      n_fail++;
      $display("[TB] FAIL bp_second_rsp: got ok=%b %h/%b/%b want %h/%b/%b",
               ok, got.rdata, got.err, got.to, e.rdata, e.err, e.to);
    end
  endtask

  task automatic test_reset_mid_access;
    bit ok, quiet;
    @(negedge PCLK);
    slave_stuck = 1;
    issue(1'b1, 32'h40, 32'h1111_2222, 4'hF, ok);
    repeat (2) @(negedge PCLK);
    n_cmp++;
    if (!ok || PENABLE !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_in_access: got ok=%b pen=%b want 1 1", ok, PENABLE);
    end
    PRESETn = 1'b0;
    #1;
    n_cmp++;
    if ({PSELx, PENABLE, rsp_valid, req_ready} !== 4'b0 || PADDR !== '0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_outputs: got sel=%b en=%b valid=%b rdy=%b addr=%h want 0 0 0 0 0",
               PSELx, PENABLE, rsp_valid, req_ready, PADDR);
    end
    repeat (2) @(negedge PCLK);
    slave_stuck = 0;
    PRESETn = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_release_ready: got %b want 1", req_ready);
    end
    quiet = 1'b1;
    repeat (6) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || PSELx !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_no_rsp: got a response or APB activity after reset want none");
    end
  endtask

  task automatic test_timeout;
    bit ok; int pen; exp_t got, e;
    @(negedge PCLK);
    slave_stuck = 1; slave_wait = 0;
`ifdef APB_TIMEOUT_EN
    sb_q.push_back('{rdata: '0, err: 1'b1, to: 1'b1});
`endif
    issue(1'b0, 32'h30, 32'h0, 4'h0, ok);
    @(negedge PCLK);
    pen = 0;
    while (PENABLE === 1'b1 && pen < 40) begin
      pen++;
      @(negedge PCLK);
    end
`ifdef APB_TIMEOUT_EN
    n_cmp++;
    if (!ok || pen != 16) begin
      n_fail++;
      $display("[TB] FAIL to_access_cycles: got ok=%b cycles=%0d want 1 16", ok, pen);
    end
    wait_rsp(got, ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (!ok || got !== e) begin
      n_fail++;
      $display("[TB] FAIL to_rsp: got ok=%b %h/%b/%b want %h/%b/%b",
               ok, got.rdata, got.err, got.to, e.rdata, e.err, e.to);
    end
    // PREADY arriving in the 16th ACCESS cycle completes normally
    @(negedge PCLK);
    slave_stuck = 0; slave_wait = 15; slave_rdata = 32'h600D_F00D;
    sb_q.push_back('{rdata: 32'h600D_F00D, err: 1'b0, to: 1'b0});
    issue(1'b0, 32'h34, 32'h0, 4'h0, ok);
    wait_rsp(got, ok);
    e = sb_q.pop_front();
    n_cmp++;
    if (!ok || got !== e) begin
      n_fail++;
      $display("[TB] FAIL to_edge_normal: got ok=%b %h/%b/%b want %h/%b/%b",
               ok, got.rdata, got.err, got.to, e.rdata, e.err, e.to);
    end
`else
    n_cmp++;
    if (!ok || pen != 40 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL no_to_wait: got ok=%b cycles=%0d valid=%b to=%b want 1 40 0 0",
               ok, pen, rsp_valid, rsp_timeout);
    end
    PRESETn = 1'b0;
    @(negedge PCLK);
    slave_stuck = 0;
    PRESETn = 1'b1;
`endif
    slave_wait = 0;
  endtask

  task automatic test_back_to_back;
    bit accepted, spacing_ok; int idx, nrsp, last_acc; exp_t got, e;
    logic [AW-1:0] a;
    @(negedge PCLK);
    slave_wait = 0; slave_err = 0; slave_stuck = 0; use_addr_data = 1; rsp_ready = 1;
    idx = 0; nrsp = 0; last_acc = -1; spacing_ok = 1'b1;
    a = 32'h100;
    req_write = 1'b0; req_addr = a; req_wdata = 32'h0; req_strb = 4'hF; req_valid = 1'b1;
    for (int c = 0; c < 60 && nrsp < 4; c++) begin
      accepted = 1'b0;
      if (rsp_valid === 1'b1) begin
        got = '{rdata: rsp_rdata, err: rsp_err, to: rsp_timeout};
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL b2b_rsp: got unexpected response %h want none", got.rdata);
        end else begin
          e = sb_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("[TB] FAIL b2b_rsp: got %h/%b/%b want %h/%b/%b",
                     got.rdata, got.err, got.to, e.rdata, e.err, e.to);
          end
        end
        nrsp++;
      end
      if (req_valid && req_ready === 1'b1) begin
        if (last_acc >= 0 && (cyc - last_acc) != 4) spacing_ok = 1'b0;
        last_acc = cyc;
        sb_q.push_back('{rdata: req_write ? 32'h0 : {~req_addr[15:0], req_addr[15:0]},
                         err: 1'b0, to: 1'b0});
        idx++;
        accepted = 1'b1;
      end
      @(negedge PCLK);
      if (accepted) begin
        if (idx < 4) begin
          a = 32'h100 + 32'(4 * idx);
          req_write = idx[0]; req_addr = a; req_wdata = 32'hABC0_0000 | a;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (nrsp != 4 || idx != 4) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got accepted=%0d responses=%0d want 4 4", idx, nrsp);
    end
    n_cmp++;
    if (!spacing_ok) begin
      n_fail++;
      $display("[TB] FAIL b2b_spacing: got request spacing other than 4 cycles want 4");
    end
    use_addr_data = 0;
  endtask

  // overall time bound so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by 200000 want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_strb = '0;
    rsp_ready = 1; slave_wait = 0; slave_stuck = 0; slave_err = 0;
    use_addr_data = 0; slave_rdata = '0;
    $display("[TB] start");
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slave_error();
    test_backpressure();
    test_reset_mid_access();
    test_timeout();
    test_back_to_back();
    repeat (2) @(negedge PCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
